// File: rtl/systolic_array_ctrl.sv
// Sequencer for a 4x4 8-bit systolic array: buffers operand rows, streams the
// skewed A/B wavefronts with a feed index, then captures the packed C rows.
module systolic_array_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_SIZE  = 8,
  parameter int DIM_SIZE   = 4,
  parameter int TIMEOUT    = 4
) (
  input  logic                  systolic_clk,
  input  logic                  rst_n,
  input  logic                  ld_valid,
  input  logic                  ld_sel,
  input  logic [1:0]            ld_row,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  c_valid,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] c_row0,
  output logic [DATA_WIDTH-1:0] c_row1,
  output logic [DATA_WIDTH-1:0] c_row2,
  output logic [DATA_WIDTH-1:0] c_row3,
  output logic                  arr_rst_n,
  output logic                  arr_enable,
  output logic [DATA_WIDTH-1:0] rowA,
  output logic [DATA_WIDTH-1:0] rowB,
  output logic [3:0]            clk_count,
  input  logic                  arr_done,
  input  logic [DATA_WIDTH-1:0] arr_c0,
  input  logic [DATA_WIDTH-1:0] arr_c1,
  input  logic [DATA_WIDTH-1:0] arr_c2,
  input  logic [DATA_WIDTH-1:0] arr_c3
);

  localparam int IDX_W  = $clog2(DIM_SIZE);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [3:0] T_FEED_END  = 4'(2 * DIM_SIZE - 2);
  localparam logic [3:0] T_DRAIN_END = 4'(3 * DIM_SIZE - 2);
  localparam logic [3:0] CNT_AFTER   = T_DRAIN_END + 4'd1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_DRAIN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state_reg, state_next;
  logic [3:0]        t_reg, t_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              err_next;
  logic              capture;
  logic              feed_next;
  logic [3:0]        clk_count_next;
  logic [DATA_WIDTH-1:0] row_a_next, row_b_next;

  logic [DATA_SIZE-1:0] a_buf [DIM_SIZE][DIM_SIZE];
  logic [DATA_SIZE-1:0] b_buf [DIM_SIZE][DIM_SIZE];

  // Operand buffers keep their contents across reset and across runs.
  always_ff @(posedge systolic_clk) begin
    if (ld_valid && state_reg == S_IDLE) begin
      for (int k = 0; k < DIM_SIZE; k++) begin
        if (ld_sel)
          b_buf[ld_row][k] <= ld_data[DATA_WIDTH-1-k*DATA_SIZE -: DATA_SIZE];
        else
          a_buf[ld_row][k] <= ld_data[DATA_WIDTH-1-k*DATA_SIZE -: DATA_SIZE];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    wait_next  = wait_reg;
    err_next   = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        t_next = '0;
        if (start) state_next = S_CLR;
      end
      S_CLR: begin
        t_next     = '0;
        state_next = S_FEED;
      end
      S_FEED: begin
        t_next = t_reg + 4'd1;
        if (t_reg == T_FEED_END) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        t_next    = t_reg + 4'd1;
        wait_next = '0;
        if (t_reg == T_DRAIN_END) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (arr_done) begin
          state_next = S_DONE;
          capture    = 1'b1;
        end else if (wait_reg == WAIT_LAST) begin
          state_next = S_IDLE;
          err_next   = 1'b1;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    feed_next = (state_next == S_FEED) || (state_next == S_DRAIN);
    if (feed_next)
      clk_count_next = t_next;
    else if (state_next == S_WAIT || state_next == S_DONE)
      clk_count_next = CNT_AFTER;
    else
      clk_count_next = 4'd0;
  end

  // Skewed wavefronts, computed for the upcoming cycle so they leave registered.
  // t - i wraps to a large value when t < i, so one upper bound check suffices.
  genvar gi;
  generate
    for (gi = 0; gi < DIM_SIZE; gi++) begin : g_skew
      logic [3:0] ka;
      logic [3:0] kb;
      assign ka = t_next - 4'(gi);
      assign kb = t_next - 4'(gi);
      assign row_a_next[DATA_WIDTH-1-gi*DATA_SIZE -: DATA_SIZE] =
        (feed_next && ka <= 4'(DIM_SIZE - 1)) ? a_buf[gi][ka[IDX_W-1:0]] : '0;
      assign row_b_next[DATA_WIDTH-1-gi*DATA_SIZE -: DATA_SIZE] =
        (feed_next && kb <= 4'(DIM_SIZE - 1)) ? b_buf[kb[IDX_W-1:0]][gi] : '0;
    end
  endgenerate

  always_ff @(posedge systolic_clk) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      t_reg      <= '0;
      wait_reg   <= '0;
      busy       <= 1'b0;
      c_valid    <= 1'b0;
      err        <= 1'b0;
      arr_rst_n  <= 1'b0;
      arr_enable <= 1'b0;
      rowA       <= '0;
      rowB       <= '0;
      clk_count  <= '0;
      c_row0     <= '0;
      c_row1     <= '0;
      c_row2     <= '0;
      c_row3     <= '0;
    end else begin
      state_reg  <= state_next;
      t_reg      <= t_next;
      wait_reg   <= wait_next;
      busy       <= (state_next != S_IDLE);
      c_valid    <= (state_next == S_DONE);
      err        <= err_next;
      arr_rst_n  <= (state_next != S_CLR);
      arr_enable <= feed_next || (state_next == S_WAIT);
      rowA       <= row_a_next;
      rowB       <= row_b_next;
      clk_count  <= clk_count_next;
      if (capture) begin
        c_row0 <= arr_c0;
        c_row1 <= arr_c1;
        c_row2 <= arr_c2;
        c_row3 <= arr_c3;
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl driving a behavioural 4x4 systolic
// array, with hand-computed expected results for each scenario.
module tb_systolic_array_ctrl;

  logic        systolic_clk = 1'b0;
  logic        rst_n, ld_valid, ld_sel, start;
  logic [1:0]  ld_row;
  logic [31:0] ld_data;
  logic        busy, c_valid, err, arr_rst_n, arr_enable;
  logic [31:0] c_row0, c_row1, c_row2, c_row3, rowA, rowB;
  logic [3:0]  clk_count;
  logic        arr_done = 1'b0;
  logic [31:0] arr_c0, arr_c1, arr_c2, arr_c3;

  int n_checks = 0;
  int n_errors = 0;
  logic done_tie0 = 1'b0;

  systolic_array_ctrl #(
    .DATA_WIDTH(32), .DATA_SIZE(8), .DIM_SIZE(4), .TIMEOUT(4)
  ) dut (
    .systolic_clk(systolic_clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_row(ld_row), .ld_data(ld_data),
    .start(start), .busy(busy), .c_valid(c_valid), .err(err),
    .c_row0(c_row0), .c_row1(c_row1), .c_row2(c_row2), .c_row3(c_row3),
    .arr_rst_n(arr_rst_n), .arr_enable(arr_enable),
    .rowA(rowA), .rowB(rowB), .clk_count(clk_count),
    .arr_done(arr_done),
    .arr_c0(arr_c0), .arr_c1(arr_c1), .arr_c2(arr_c2), .arr_c3(arr_c3)
  );

  always #5 systolic_clk = ~systolic_clk;

  // Behavioural output-stationary array: A flows right, B flows down.
  logic [7:0] pa [4][4];
  logic [7:0] pb [4][4];
  logic [7:0] acc [4][4];

  function automatic logic [7:0] a_in(int i, int j);
    if (j == 0) return rowA[31-8*i -: 8];
    return pa[i][j-1];
  endfunction

  function automatic logic [7:0] b_in(int i, int j);
    if (i == 0) return rowB[31-8*j -: 8];
    return pb[i-1][j];
  endfunction

  always @(posedge systolic_clk) begin
    if (!arr_rst_n) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          pa[i][j]  <= 8'd0;
          pb[i][j]  <= 8'd0;
          acc[i][j] <= 8'd0;
        end
      arr_done <= 1'b0;
    end else begin
      if (arr_enable)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            pa[i][j]  <= a_in(i, j);
            pb[i][j]  <= b_in(i, j);
            acc[i][j] <= acc[i][j] + 8'(a_in(i, j) * b_in(i, j));
          end
      arr_done <= arr_enable && (clk_count == 4'd10) && !done_tie0;
    end
  end

  assign arr_c0 = {acc[0][0], acc[0][1], acc[0][2], acc[0][3]};
  assign arr_c1 = {acc[1][0], acc[1][1], acc[1][2], acc[1][3]};
  assign arr_c2 = {acc[2][0], acc[2][1], acc[2][2], acc[2][3]};
  assign arr_c3 = {acc[3][0], acc[3][1], acc[3][2], acc[3][3]};

  // Per-cycle log of one run, indexed by cycles after the start edge.
  logic [31:0] log_rowa [0:20];
  logic [31:0] log_rowb [0:20];
  logic [31:0] log_crow0 [0:20];
  logic [3:0]  log_cnt [0:20];
  logic        log_busy [0:20];
  logic        log_arst [0:20];
  logic        log_en [0:20];
  int cv_cyc, cv_cnt, err_cyc, err_cnt, cnt10, run_no = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge systolic_clk);
    #1;
  endtask

  task automatic load_row(input logic sel, input logic [1:0] row, input logic [31:0] data);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_row   = row;
    ld_data  = data;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic load_mat(input logic sel, input logic [31:0] r0, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] r3);
    load_row(sel, 2'd0, r0);
    load_row(sel, 2'd1, r1);
    load_row(sel, 2'd2, r2);
    load_row(sel, 2'd3, r3);
  endtask

  // start is sampled at edge 0; inj_cyc pulses start + an A row 0 write,
  // rst_cyc pulls rst_n low for one cycle.
  task automatic do_run(input logic ld_now, input logic [31:0] ld_word,
                        input int inj_cyc, input int rst_cyc);
    start = 1'b1;
    if (ld_now) begin
      ld_valid = 1'b1;
      ld_sel   = 1'b0;
      ld_row   = 2'd0;
      ld_data  = ld_word;
    end
    cv_cyc = -1; cv_cnt = 0; err_cyc = -1; err_cnt = 0; cnt10 = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start    = 1'b0;
      ld_valid = 1'b0;
      rst_n    = 1'b1;
      if (c == inj_cyc) begin
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_row   = 2'd0;
        ld_data  = 32'h02000000;
      end
      if (c == rst_cyc) rst_n = 1'b0;
      log_rowa[c]  = rowA;
      log_rowb[c]  = rowB;
      log_crow0[c] = c_row0;
      log_cnt[c]   = clk_count;
      log_busy[c]  = busy;
      log_arst[c]  = arr_rst_n;
      log_en[c]    = arr_enable;
      if (c_valid) begin cv_cnt++; cv_cyc = c; end
      if (err) begin err_cnt++; err_cyc = c; end
      if (clk_count == 4'd10) cnt10++;
    end
    run_no++;
    $display("run %0d: c_valid at %0d (x%0d) err at %0d (x%0d) c_row0=%h c_row3=%h",
             run_no, cv_cyc, cv_cnt, err_cyc, err_cnt, c_row0, c_row3);
  endtask

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_row = 2'd0;
    ld_data = 32'h0; start = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_c_valid", c_valid, 0);
    check("rst_err", err, 0);
    check("rst_c_row0", c_row0, 0);
    check("rst_arr_rst_n", arr_rst_n, 0);
    check("rst_arr_enable", arr_enable, 0);
    check("rst_rowA", rowA, 0);
    check("rst_clk_count", clk_count, 0);
    rst_n = 1'b1;
    tick();
    check("idle_arr_rst_n", arr_rst_n, 1);
    check("idle_busy", busy, 0);

    // Identity A: C = B
    load_mat(1'b0, 32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001);
    load_mat(1'b1, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
    do_run(1'b0, 32'h0, -1, -1);
    check("id_cv_cycle", cv_cyc, 14);
    check("id_cv_count", cv_cnt, 1);
    check("id_busy_c1", log_busy[1], 1);
    check("id_busy_c14", log_busy[14], 1);
    check("id_busy_c15", log_busy[15], 0);
    check("id_arst_clr", log_arst[1], 0);
    check("id_arst_feed", log_arst[2], 1);
    check("id_en_clr", log_en[1], 0);
    check("id_en_feed", log_en[2], 1);
    check("id_c_row0", c_row0, 32'h01020304);
    check("id_c_row1", c_row1, 32'h05060708);
    check("id_c_row2", c_row2, 32'h090A0B0C);
    check("id_c_row3", c_row3, 32'h0D0E0F10);
    check("id_err", err_cnt, 0);
    check("id_cnt10", cnt10, 1);

    // All 0xFF: 4 * (255*255 mod 256) = 4
    load_mat(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    load_mat(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_run(1'b0, 32'h0, -1, -1);
    check("wrap_cv_cycle", cv_cyc, 14);
    check("wrap_c_row0", c_row0, 32'h04040404);
    check("wrap_c_row1", c_row1, 32'h04040404);
    check("wrap_c_row2", c_row2, 32'h04040404);
    check("wrap_c_row3", c_row3, 32'h04040404);

    // Skew: A row r = r+1 everywhere, B = all ones
    load_mat(1'b0, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404);
    load_mat(1'b1, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    do_run(1'b0, 32'h0, -1, -1);
    check("skew_rowA_clr", log_rowa[1], 32'h0);
    check("skew_rowA_t0", log_rowa[2], 32'h01000000);
    check("skew_rowA_t3", log_rowa[5], 32'h01020304);
    check("skew_rowA_t6", log_rowa[8], 32'h00000004);
    check("skew_rowA_t7", log_rowa[9], 32'h0);
    check("skew_rowA_wait", log_rowa[13], 32'h0);
    check("skew_rowB_t0", log_rowb[2], 32'h01000000);
    check("skew_rowB_t3", log_rowb[5], 32'h01010101);
    check("skew_rowB_t6", log_rowb[8], 32'h00000001);
    check("skew_cnt_clr", log_cnt[1], 0);
    check("skew_cnt_t3", log_cnt[5], 3);
    check("skew_cnt_t10", log_cnt[12], 10);
    check("skew_cnt_wait", log_cnt[13], 11);
    check("skew_cnt10_once", cnt10, 1);
    check("skew_c_row0", c_row0, 32'h04040404);
    check("skew_c_row1", c_row1, 32'h08080808);
    check("skew_c_row3", c_row3, 32'h10101010);

    // start + load during FEED are ignored
    load_mat(1'b0, 32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001);
    load_mat(1'b1, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
    do_run(1'b0, 32'h0, 4, -1);
    check("ign_cv_count", cv_cnt, 1);
    check("ign_cv_cycle", cv_cyc, 14);
    check("ign_busy_c18", log_busy[18], 0);
    check("ign_c_row0", c_row0, 32'h01020304);
    do_run(1'b0, 32'h0, -1, -1);
    check("ign_old_row_cv", cv_cnt, 1);
    check("ign_old_row_c0", c_row0, 32'h01020304);

    // load + start in the same IDLE cycle: the new row is used
    do_run(1'b1, 32'h02000000, -1, -1);
    check("same_cv_cycle", cv_cyc, 14);
    check("same_c_row0", c_row0, 32'h02040608);
    check("same_c_row1", c_row1, 32'h05060708);

    // Reset mid-run
    do_run(1'b0, 32'h0, -1, 6);
    check("mrst_busy_c6", log_busy[6], 1);
    check("mrst_busy_c7", log_busy[7], 0);
    check("mrst_rowA_c7", log_rowa[7], 32'h0);
    check("mrst_c_row0_c7", log_crow0[7], 32'h0);
    check("mrst_arst_c7", log_arst[7], 0);
    check("mrst_no_cv", cv_cnt, 0);
    check("mrst_busy_c20", log_busy[20], 0);
    load_row(1'b0, 2'd0, 32'h01000000);
    do_run(1'b0, 32'h0, -1, -1);
    check("post_cv_cycle", cv_cyc, 14);
    check("post_c_row0", c_row0, 32'h01020304);
    check("post_c_row3", c_row3, 32'h0D0E0F10);

    // Timeout: array never reports done
    done_tie0 = 1'b1;
    do_run(1'b0, 32'h0, -1, -1);
    done_tie0 = 1'b0;
    check("to_err_cycle", err_cyc, 17);
    check("to_err_count", err_cnt, 1);
    check("to_no_cv", cv_cnt, 0);
    check("to_busy_c16", log_busy[16], 1);
    check("to_busy_c17", log_busy[17], 0);
    check("to_cnt_c16", log_cnt[16], 11);
    check("to_c_row0", c_row0, 32'h01020304);
    check("to_c_row3", c_row3, 32'h0D0E0F10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
